// File: rtl/aclk_load_arbiter.sv
// Two-requester arbiter for the alarm clock core's time/alarm load port.
// Validates BCD, sequences the LD strobes and data, reads time loads back and acks.
module aclk_load_arbiter #(
  parameter int LOAD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_alarm,
  input  logic [13:0] r0_data,
  output logic        r0_ack,
  input  logic        r1_req,
  input  logic        r1_alarm,
  input  logic [13:0] r1_data,
  output logic        r1_ack,
  output logic [1:0]  err,
  output logic        busy,
  output logic [1:0]  H_in1,
  output logic [3:0]  H_in0,
  output logic [3:0]  M_in1,
  output logic [3:0]  M_in0,
  output logic        LD_time,
  output logic        LD_alarm,
  input  logic [1:0]  H_out1,
  input  logic [3:0]  H_out0,
  input  logic [3:0]  M_out1,
  input  logic [3:0]  M_out0
);

  typedef enum logic [2:0] {IDLE, CHECK, DRIVE, SETTLE, VERIFY, DONE} state_t;
  typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_BCD = 2'b01, ERR_READBACK = 2'b10} err_t;

  localparam logic [7:0] LOAD_LAST   = 8'(LOAD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  err_t        code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  armed_q, armed_d;
  logic        rr_last_q;
  logic        win_q;
  logic [13:0] data_q;
  logic        alarm_q;

  logic [1:0]  eligible;
  logic        grant_valid;
  logic        grant_idx;
  logic        readback_ok;

  function automatic logic bcd_ok(input logic [13:0] d);
    int h1, h0, m1, m0;
    h1 = int'(d[13:12]);
    h0 = int'(d[11:8]);
    m1 = int'(d[7:4]);
    m0 = int'(d[3:0]);
    return (h1 <= 2) && (h0 <= 9) && (h1 * 10 + h0 <= 23) && (m1 <= 5) && (m0 <= 9);
  endfunction

  assign eligible    = {r1_req & armed_q[1], r0_req & armed_q[0]};
  assign grant_valid = (state_q == IDLE) && (|eligible);
  // On a tie the requester that did not win last time goes first.
  assign grant_idx   = (&eligible) ? ~rr_last_q : eligible[1];
  assign readback_ok = ({H_out1, H_out0, M_out1, M_out0} == data_q);

  always_comb begin
    armed_d = armed_q;
    for (int i = 0; i < 2; i++) begin
      if (!(i == 0 ? r0_req : r1_req))
        armed_d[i] = 1'b1;
      else if (grant_valid && (grant_idx == 1'(i)))
        armed_d[i] = 1'b0;
    end
  end

  // State register and transaction context.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      code_q    <= ERR_OK;
      cnt_q     <= '0;
      armed_q   <= 2'b11;
      rr_last_q <= 1'b1;
      win_q     <= 1'b0;
      data_q    <= '0;
      alarm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      if (grant_valid) begin
        rr_last_q <= grant_idx;
        win_q     <= grant_idx;
        data_q    <= grant_idx ? r1_data : r0_data;
        alarm_q   <= grant_idx ? r1_alarm : r0_alarm;
      end
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        code_d = ERR_OK;
        if (|eligible) state_d = CHECK;
      end
      CHECK: begin
        if (bcd_ok(data_q)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          // A rejected request lingers one extra cycle so the error ack lands two edges after grant.
          code_d = ERR_BCD;
          if (cnt_q == '0) cnt_d = 8'd1;
          else             state_d = DONE;
        end
      end
      DRIVE: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = alarm_q ? DONE : VERIFY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      VERIFY: begin
        code_d  = readback_ok ? ERR_OK : ERR_READBACK;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      err      <= 2'b00;
      busy     <= 1'b0;
      LD_time  <= 1'b0;
      LD_alarm <= 1'b0;
      H_in1    <= '0;
      H_in0    <= '0;
      M_in1    <= '0;
      M_in0    <= '0;
    end else begin
      r0_ack   <= (state_d == DONE) && !win_q;
      r1_ack   <= (state_d == DONE) && win_q;
      err      <= (state_d == DONE) ? code_d : ERR_OK;
      busy     <= (state_d != IDLE);
      LD_time  <= (state_d == DRIVE) && !alarm_q;
      LD_alarm <= (state_d == DRIVE) && alarm_q;
      if ((state_q == CHECK) && (state_d == DRIVE))
        {H_in1, H_in0, M_in1, M_in0} <= data_q;
    end
  end

endmodule

// File: doc/aclk_load_arbiter.md
Name: aclk_load_arbiter

Overview:
- Arbitrates two requesters for the time/alarm load interface of the alarm clock core (aclock): requester 0 is the time-sync source and requester 1 is the user-set path.
- Validates each requested BCD value, then sequences the H_in*/M_in* data and the LD_time/LD_alarm strobe into the core.
- For time loads, reads the core outputs back and reports a per-request status with a one-cycle ack.

Parameters:
- LOAD_CYCLES, 1, cycles LD_time/LD_alarm is held high (≥1)
- SETTLE_CYCLES, 2, cycles data is held with LD low before verify/ack (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- r0_req  in  1  requester 0 request (level)
- r0_alarm  in  1  1 = alarm load, 0 = time load; valid while r0_req high
- r0_data  in  14  {H1[13:12],H0[11:8],M1[7:4],M0[3:0]} BCD; stable while r0_req high
- r0_ack  out  1  one-cycle completion pulse
- r1_req, r1_alarm, r1_data, r1_ack  same as r0_* for requester 1
- err  out  2  status, valid while either ack is high: 00 ok, 01 invalid BCD, 10 readback mismatch
- busy  out  1  high in any state other than IDLE
- H_in1  out  2,  H_in0  out  4,  M_in1  out  4,  M_in0  out  4  to core
- LD_time  out  1,  LD_alarm  out  1  to core
- H_out1  in  2,  H_out0  in  4,  M_out1  in  4,  M_out0  in  4  core readback

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; armed[1:0]=2'b11; rr_last=1, so r0 wins the first tie. Reset mid-transaction aborts it immediately: LD drops, no ack.
- All outputs are registered. No combinational path from any input to any output.
- Arm rule: armed[i] clears on grant and sets on any edge that samples ri_req=0. A requester must drop req for ≥1 cycle between transactions. A held req is never re-granted.
- States: IDLE, CHECK, DRIVE, SETTLE, VERIFY, DONE.
- IDLE → CHECK when any ri_req & armed[i] is set.
  - Both eligible: grant the index ≠ rr_last.
  - Update rr_last to the winner and latch winner, data and alarm.
  - A losing request waits and is not lost.
- CHECK (1 cycle): data is valid iff H1≤2, H0≤9, H1*10+H0≤23, M1≤5, M0≤9.
  - Invalid → DONE with err=01. LD never asserts and the H_in/M_in outputs keep their previous values.
  - Valid → DRIVE. H_in*/M_in* take the latched data on entry.
- DRIVE (LOAD_CYCLES cycles): LD_alarm=1 if alarm, else LD_time=1. Only one LD is ever high. Then → SETTLE.
- SETTLE (SETTLE_CYCLES cycles): LD low, data held. Then → VERIFY for a time load, → DONE for an alarm load.
- VERIFY (1 cycle): compare {H_out1,H_out0,M_out1,M_out0} to latched data. Mismatch sets err=10, match sets err=00. Then → DONE.
- DONE (1 cycle): the winner's ri_ack=1 and err is valid; the other ack stays 0. Then → IDLE.
- H_in*/M_in* hold their last driven value until the next valid load.
- Latency from the IDLE edge that samples the request to the ack-high cycle:
  - Valid time load: 2+LOAD_CYCLES+SETTLE_CYCLES edges (5 with defaults).
  - Alarm load: 1+LOAD_CYCLES+SETTLE_CYCLES (4).
  - Invalid BCD: 2.
- Protocol violations: if ri_req or ri_data changes mid-transaction, the latched copy is used and the ack is still issued.
- Requests arriving during busy are only evaluated back in IDLE. Maximum wait for a request is one foreign transaction.
- err=00 and both acks=0 outside DONE.

Test Plan:
- r0 time load 12:34, defaults → LD_time high exactly 1 cycle with H_in1=1, H_in0=2, M_in1=3, M_in0=4; r0_ack 5 cycles after sampling edge; err=00; core reads 12:34:00.
- r1 alarm load 07:05 → LD_alarm pulses 1 cycle, LD_time stays 0, r1_ack after 4 cycles, err=00; core Alarm asserts when time reaches 07:05 with AL_ON=1.
- r0 data 24:00, then 13:60 → no LD pulse, outputs unchanged, r0_ack after 2 cycles, err=01 each time.
- r0 and r1 raise req on the same edge after reset → r0 served first, r1 ack follows; repeat with both re-armed → r1 first (round-robin); r0 holding req high after ack gets no second grant until it drops req.
- Force core readback mismatch (stub H_out0=9 for 12:34 load) → r0_ack with err=10.
- Assert reset during DRIVE → LD_time low asynchronously, no ack, busy=0; next request completes normally with r0 priority.
